fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter_if.sv | 39 +++
 rtl/fb_arbiter.sv | 121 ++++++++++++
 tb/tb_fb_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: scanout read port, renderer write port, clear control and RAM port.
// slave is the arbiter side; master is the clients plus RAM side.
interface fb_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_gnt;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_rvalid;
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  scan_req, scan_addr, draw_req, draw_addr, draw_wdata,
           clear_start, clear_color, mem_rdata,
    output scan_gnt, scan_rdata, scan_rvalid, draw_gnt, clear_busy, clear_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output scan_req, scan_addr, draw_req, draw_addr, draw_wdata,
           clear_start, clear_color, mem_rdata,
    input  scan_gnt, scan_rdata, scan_rvalid, draw_gnt, clear_busy, clear_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads beat draw/clear writes until the starve limit.
// Grants are combinational; read data returns one cycle after scan_gnt.
module fb_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4096,
  parameter int STARVE_LIMIT = 7
) (
  input logic         clk,
  input logic         rst,
  fb_arbiter_if.slave bus
);
  typedef enum logic {IDLE, SWEEP} state_e;

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              done_q, done_d;
  logic              rvalid_q;

  logic busy, lp_pend, lp_win, scan_gnt, draw_gnt, clr_gnt;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      color_q  <= '0;
      starve_q <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      rvalid_q <= scan_gnt;
    end
  end

  // Low-priority slot belongs to the clear engine for the whole sweep.
  always_comb begin
    busy     = (state_q == SWEEP);
    lp_pend  = busy | bus.draw_req;
    lp_win   = lp_pend & (~bus.scan_req | (starve_q == STARVE_MAX));
    scan_gnt = bus.scan_req & ~lp_win;
    draw_gnt = lp_win & ~busy;
    clr_gnt  = lp_win & busy;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    color_d  = color_q;
    done_d   = 1'b0;
    starve_d = '0;
    if (lp_pend && !lp_win)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          color_d = bus.clear_color;
        end
      end
      SWEEP: begin
        if (clr_gnt) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (scan_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.scan_addr;
    end else if (draw_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = bus.draw_addr;
      mem_wdata = bus.draw_wdata;
    end else if (clr_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = color_q;
    end
  end

  assign bus.scan_gnt    = scan_gnt;
  assign bus.draw_gnt    = draw_gnt;
  assign bus.scan_rvalid = rvalid_q;
  assign bus.scan_rdata  = bus.mem_rdata;
  assign bus.clear_busy  = busy;
  assign bus.clear_done  = done_q;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM model plus a framebuffer-level reference model of arbitration and clear.
module tb_fb_arbiter;
  localparam int DEPTH = 16;
  localparam int LIMIT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(12), .DATA_W(8)) io ();

  fb_arbiter #(.ADDR_W(12), .DATA_W(8), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(io)
  );

  logic [7:0] ram [0:4095];
  logic [7:0] fb  [0:4095];

  always @(posedge clk) begin
    if (io.mem_en) begin
      if (io.mem_we) ram[io.mem_addr] <= io.mem_wdata;
      else           io.mem_rdata     <= ram[io.mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int m_starve = 0;
  int m_cnt = 0;
  bit m_busy = 1'b0;
  logic [7:0] m_color = 8'h00;
  int n_draw, n_busy, n_clr_wr, n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_cnt    = 0;
    m_busy   = 1'b0;
  endtask

  task automatic cycle(input logic sr, input logic [11:0] sa, input logic dr,
                       input logic [11:0] da, input logic [7:0] dd,
                       input logic cs, input logic [7:0] cc);
    bit lp_pend, lp_win, e_scan, e_draw, e_clr, e_done;
    logic [11:0] e_addr;
    logic [7:0]  e_wdata, rd_exp;
    io.scan_req = sr; io.scan_addr = sa;
    io.draw_req = dr; io.draw_addr = da; io.draw_wdata = dd;
    io.clear_start = cs; io.clear_color = cc;
    #4;
    lp_pend = m_busy || dr;
    lp_win  = lp_pend && (!sr || m_starve >= LIMIT);
    e_scan  = sr && !lp_win;
    e_draw  = lp_win && !m_busy;
    e_clr   = lp_win && m_busy;
    e_addr  = e_scan ? sa : (e_draw ? da : 12'(m_cnt));
    e_wdata = e_draw ? dd : m_color;
    rd_exp  = fb[sa];
    chk("scan_gnt", io.scan_gnt, e_scan);
    chk("draw_gnt", io.draw_gnt, e_draw);
    chk("mem_en", io.mem_en, e_scan || e_draw || e_clr);
    chk("mem_we", io.mem_we, e_draw || e_clr);
    if (e_scan || e_draw || e_clr) chk("mem_addr", io.mem_addr, e_addr);
    if (e_draw || e_clr) chk("mem_wdata", io.mem_wdata, e_wdata);
    if (io.draw_gnt) n_draw++;
    if (io.clear_busy) n_busy++;
    if (io.clear_busy && io.mem_en && io.mem_we) n_clr_wr++;
    @(posedge clk);
    #1;
    if (e_draw) fb[da] = dd;
    if (e_clr) fb[m_cnt] = m_color;
    if (lp_pend && !lp_win) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
    e_done = 1'b0;
    if (!m_busy) begin
      if (cs) begin m_busy = 1'b1; m_cnt = 0; m_color = cc; end
    end else if (e_clr) begin
      if (m_cnt == DEPTH - 1) begin m_busy = 1'b0; m_cnt = 0; e_done = 1'b1; end
      else m_cnt++;
    end
    if (io.clear_done) n_done++;
    chk("clear_busy", io.clear_busy, m_busy);
    chk("clear_done", io.clear_done, e_done);
    chk("scan_rvalid", io.scan_rvalid, e_scan);
    if (e_scan) chk("scan_rdata", io.scan_rdata, rd_exp);
  endtask

  task automatic idle();
    cycle(1'b0, 12'h0, 1'b0, 12'h0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) begin ram[i] = 8'h00; fb[i] = 8'h00; end
    io.mem_rdata = 8'h00;
    io.scan_req = 1'b0; io.scan_addr = '0;
    io.draw_req = 1'b0; io.draw_addr = '0; io.draw_wdata = '0;
    io.clear_start = 1'b0; io.clear_color = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", io.clear_busy, 1'b0);
    chk("rst_done", io.clear_done, 1'b0);
    chk("rst_rvalid", io.scan_rvalid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write a known pixel, then read it back through the scan port.
    cycle(1'b0, 12'h0, 1'b1, 12'h010, 8'hA5, 1'b0, 8'h00);
    cycle(1'b1, 12'h010, 1'b0, 12'h0, 8'h00, 1'b0, 8'h00);
    chk("scan_read_a5", io.scan_rdata, 8'hA5);

    // Both requesters held: renderer gets every eighth slot.
    n_draw = 0;
    for (int i = 0; i < 24; i++)
      cycle(1'b1, 12'(i), 1'b1, 12'(32 + i), 8'(i), 1'b0, 8'h00);
    chk("starve_draw_count", n_draw, 3);
    idle();

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), 8'($urandom),
            ($urandom_range(0, 49) == 0), 8'($urandom));
    k = 0;
    while (m_busy && k < 2000) begin idle(); k++; end
    chk("random_drain", m_busy, 1'b0);

    // Plain clear of the whole framebuffer.
    n_busy = 0; n_clr_wr = 0; n_done = 0;
    cycle(1'b0, 12'h0, 1'b0, 12'h0, 8'h00, 1'b1, 8'h3C);
    repeat (DEPTH + 2) idle();
    chk("clear_busy_cycles", n_busy, DEPTH);
    chk("clear_writes", n_clr_wr, DEPTH);
    chk("clear_done_pulses", n_done, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 12'(i), 1'b0, 12'h0, 8'h00, 1'b0, 8'h00);
      chk("clear_data", io.scan_rdata, 8'h3C);
    end

    // Clear with renderer pending and a second start mid-sweep.
    cycle(1'b0, 12'h0, 1'b1, 12'h003, 8'h11, 1'b0, 8'h00);
    cycle(1'b0, 12'h0, 1'b0, 12'h0, 8'h00, 1'b1, 8'h3C);
    n_draw = 0; n_done = 0;
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 12'h0, 1'b1, 12'h014, 8'h77, (i == 5), 8'hFF);
    chk("draw_during_clear", n_draw, 0);
    chk("clear2_done", n_done, 1);
    cycle(1'b0, 12'h0, 1'b1, 12'h014, 8'h77, 1'b0, 8'h00);
    cycle(1'b1, 12'h003, 1'b0, 12'h0, 8'h00, 1'b0, 8'h00);
    chk("restart_ignored", io.scan_rdata, 8'h3C);
    cycle(1'b1, 12'h014, 1'b0, 12'h0, 8'h00, 1'b0, 8'h00);
    chk("draw_after_clear", io.scan_rdata, 8'h77);

    // Reset in the middle of a sweep.
    cycle(1'b0, 12'h0, 1'b0, 12'h0, 8'h00, 1'b1, 8'h5A);
    k = 0;
    while (m_cnt != 5 && k < 50) begin idle(); k++; end
    chk("reach_cnt5", m_cnt, 5);
    rst = 1'b1;
    #1;
    chk("abort_busy", io.clear_busy, 1'b0);
    chk("abort_mem_en", io.mem_en, 1'b0);
    chk("abort_done", io.clear_done, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0;
    repeat (20) idle();
    chk("abort_no_done", n_done, 0);
    for (int i = 4; i < 7; i++) begin
      cycle(1'b1, 12'(i), 1'b0, 12'h0, 8'h00, 1'b0, 8'h00);
      chk("abort_data", io.scan_rdata, (i < 5) ? 8'h5A : 8'h3C);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
